// File: rtl/grf_arb_pkg.sv
// ============================================================================
//  Module      : grf_arb_pkg
//  Description : Shared types and constants for the GRF writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One register-file write: destination, value and the PC that produced it.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

  // True when a decode read address refers to a real register held in an entry.
  function automatic logic addr_hit(input logic [REG_AW-1:0] rd_addr,
                                    input logic [REG_AW-1:0] ent_addr);
    return (rd_addr != REG_ZERO) && (rd_addr == ent_addr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/grf_wb_fifo.sv
// ============================================================================
//  Module      : grf_wb_fifo
//  Description : Registered (no fall-through) FIFO of pending aux writebacks.
//                Exposes head, full/empty and per-entry valid+addr so the
//                parent can run a scoreboard CAM over buffered results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_wb_fifo
  import grf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_req_t                       push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output wb_req_t                       head,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_addr
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  C_FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic [DEPTH-1:0] valid_q,  valid_d;
  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];

  logic w_push;
  logic w_pop;

  assign full      = (count_q == C_FULL_CNT);
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign ent_valid = valid_q;

  // Ignore requests that would overflow or underflow; pointers wrap at DEPTH.
  assign w_push = push && !full;
  assign w_pop  = pop  && !empty;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent_addr
      assign ent_addr[i] = mem_q[i].addr;
    end
  endgenerate

  // Next-state for storage, pointers, occupancy and per-entry valid bits.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    if (w_push) begin
      mem_d[wr_ptr_q]   = push_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
  end

  // Control state register; reset drops everything buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
// ============================================================================
//  Module      : grf_wb_arbiter
//  Description : Shares the single GRF write port between the main pipeline
//                writeback (fixed priority) and a buffered multi-cycle aux
//                unit. Provides a starvation stall and a pending-write
//                scoreboard for decode.
//  Options     : GRF_TRACE_EN - print every granted non-$0 write at posedge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_wb_arbiter
  import grf_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [REG_AW-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  input  logic [DATA_W-1:0] aux_pc,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic              busy_rs,
  output logic              busy_rt,
  output logic              stall_req,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_wpc
);

  localparam int              SW            = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   C_STARVE_LAST = SW'(STARVE_LIMIT - 1);

  logic [SW-1:0] starve_q, starve_d;

  logic                          w_full;
  logic                          w_empty;
  wb_req_t                       w_head;
  wb_req_t                       w_aux_req;
  logic [DEPTH-1:0]              w_ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0]  w_ent_addr;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_pipe_grant;
  logic                          w_head_denied;

  assign w_aux_req = '{addr: aux_addr, data: aux_data, pc: aux_pc};

  // $0 aux results are handshaken but never stored.
  assign aux_ready     = reset || !w_full;
  assign w_push        = !reset && aux_valid && !w_full && (aux_addr != REG_ZERO);

  // Pipeline writes to $0 do not claim the port, letting the FIFO head through.
  assign w_pipe_grant  = wb_valid && (wb_addr != REG_ZERO);
  assign w_pop         = !reset && !w_pipe_grant && !w_empty;
  assign w_head_denied = !reset && w_pipe_grant && !w_empty;

  // The denial that would make the head wait STARVE_LIMIT cycles raises the stall.
  assign stall_req     = w_head_denied && (starve_q == C_STARVE_LAST);

  grf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_aux_req),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head),
    .ent_valid (w_ent_valid),
    .ent_addr  (w_ent_addr)
  );

  // Write-port mux: pipeline first, then FIFO head, otherwise idle (all zero).
  always_comb begin
    grf_we  = 1'b0;
    grf_a3  = REG_ZERO;
    grf_wd  = '0;
    grf_wpc = '0;
    if (!reset) begin
      if (w_pipe_grant) begin
        grf_we  = 1'b1;
        grf_a3  = wb_addr;
        grf_wd  = wb_data;
        grf_wpc = wb_pc;
      end else if (!w_empty) begin
        grf_we  = 1'b1;
        grf_a3  = w_head.addr;
        grf_wd  = w_head.data;
        grf_wpc = w_head.pc;
      end
    end
  end

  // Scoreboard CAM: a register is busy while any valid entry targets it,
  // including the entry leaving this cycle.
  always_comb begin
    busy_rs = 1'b0;
    busy_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && addr_hit(rs_addr, w_ent_addr[i])) busy_rs = 1'b1;
      if (w_ent_valid[i] && addr_hit(rt_addr, w_ent_addr[i])) busy_rt = 1'b1;
    end
    if (reset) begin
      busy_rs = 1'b0;
      busy_rt = 1'b0;
    end
  end

  // Starve counter: counts head denials, cleared by a pop, an empty FIFO or a stall.
  always_comb begin
    starve_d = starve_q;
    if (w_empty || w_pop || stall_req) begin
      starve_d = '0;
    end else if (w_head_denied) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Starve counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

`ifdef GRF_TRACE_EN
  // Commit trace of every real register write.
  always_ff @(posedge clk) begin
    if (grf_we && (grf_a3 != REG_ZERO)) begin
      $display("@%h: $%d <= %h", grf_wpc, grf_a3, grf_wd);
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
// ============================================================================
//  Module      : tb_grf_wb_arbiter
//  Description : Self-checking bench for grf_wb_arbiter: directed vector
//                table, hand-written multi-cycle sequences and randomized
//                traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grf_wb_arbiter;
  import grf_arb_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic        rst;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic [31:0] wbp;
    logic        auxv;
    logic [4:0]  auxa;
    logic [31:0] auxd;
    logic [31:0] auxp;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } stim_t;

  typedef struct packed {
    logic        ready;
    logic        brs;
    logic        brt;
    logic        stall;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] wpc;
  } outs_t;

  typedef struct packed {
    stim_t s;
    outs_t e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [31:0] aux_pc;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        busy_rs;
  logic        busy_rt;
  logic        stall_req;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_wpc;

  int n_cmp = 0;
  int n_bad = 0;

  outs_t   obs;
  wb_req_t mq[$];
  int      wait_cnt = 0;

  grf_wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_pc     (wb_pc),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_addr  (aux_addr),
    .aux_data  (aux_data),
    .aux_pc    (aux_pc),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .busy_rs   (busy_rs),
    .busy_rt   (busy_rt),
    .stall_req (stall_req),
    .grf_we    (grf_we),
    .grf_a3    (grf_a3),
    .grf_wd    (grf_wd),
    .grf_wpc   (grf_wpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk_s(logic rst, logic wbv, logic [4:0] wba, logic [31:0] wbd,
                                 logic [31:0] wbp, logic auxv, logic [4:0] auxa,
                                 logic [31:0] auxd, logic [31:0] auxp,
                                 logic [4:0] rs, logic [4:0] rt);
    stim_t s;
    s.rst = rst; s.wbv = wbv; s.wba = wba; s.wbd = wbd; s.wbp = wbp;
    s.auxv = auxv; s.auxa = auxa; s.auxd = auxd; s.auxp = auxp;
    s.rs = rs; s.rt = rt;
    return s;
  endfunction

  function automatic outs_t mk_e(logic ready, logic brs, logic brt, logic stall, logic we,
                                 logic [4:0] a3, logic [31:0] wd, logic [31:0] wpc);
    outs_t e;
    e.ready = ready; e.brs = brs; e.brt = brt; e.stall = stall;
    e.we = we; e.a3 = a3; e.wd = wd; e.wpc = wpc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_outs(input string tag, input outs_t a, input outs_t e);
    chk({tag, ".aux_ready"}, 32'(a.ready), 32'(e.ready));
    chk({tag, ".busy_rs"},   32'(a.brs),   32'(e.brs));
    chk({tag, ".busy_rt"},   32'(a.brt),   32'(e.brt));
    chk({tag, ".stall_req"}, 32'(a.stall), 32'(e.stall));
    chk({tag, ".grf_we"},    32'(a.we),    32'(e.we));
    chk({tag, ".grf_a3"},    32'(a.a3),    32'(e.a3));
    chk({tag, ".grf_wd"},    a.wd,         e.wd);
    chk({tag, ".grf_wpc"},   a.wpc,        e.wpc);
  endtask

  // Reference: the buffered aux writes form an ordered queue; the pipeline
  // wins the port whenever it writes a real register; the head counts how
  // many cycles in a row it has been refused.
  function automatic outs_t model_eval(stim_t s);
    outs_t e;
    bit pipe;
    e = '0;
    e.ready = 1'b1;
    if (s.rst) return e;
    pipe    = s.wbv && (s.wba != 0);
    e.ready = (mq.size() < DEPTH);
    foreach (mq[j]) begin
      if (s.rs != 0 && mq[j].addr == s.rs) e.brs = 1'b1;
      if (s.rt != 0 && mq[j].addr == s.rt) e.brt = 1'b1;
    end
    if (pipe) begin
      e.we = 1'b1; e.a3 = s.wba; e.wd = s.wbd; e.wpc = s.wbp;
      if (mq.size() > 0 && wait_cnt + 1 == STARVE_LIMIT) e.stall = 1'b1;
    end else if (mq.size() > 0) begin
      e.we = 1'b1; e.a3 = mq[0].addr; e.wd = mq[0].data; e.wpc = mq[0].pc;
    end
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    bit pipe;
    bit ready;
    wb_req_t r;
    if (s.rst) begin
      mq.delete();
      wait_cnt = 0;
      return;
    end
    pipe  = s.wbv && (s.wba != 0);
    ready = (mq.size() < DEPTH);
    if (mq.size() == 0) begin
      wait_cnt = 0;
    end else if (pipe) begin
      wait_cnt = (wait_cnt + 1 == STARVE_LIMIT) ? 0 : wait_cnt + 1;
    end else begin
      void'(mq.pop_front());
      wait_cnt = 0;
    end
    if (s.auxv && ready && s.auxa != 0) begin
      r.addr = s.auxa; r.data = s.auxd; r.pc = s.auxp;
      mq.push_back(r);
    end
  endtask

  // One clock: drive, sample at negedge, compare with the model, advance.
  task automatic cycle(input string tag, input stim_t s);
    outs_t e;
    reset = s.rst; wb_valid = s.wbv; wb_addr = s.wba; wb_data = s.wbd; wb_pc = s.wbp;
    aux_valid = s.auxv; aux_addr = s.auxa; aux_data = s.auxd; aux_pc = s.auxp;
    rs_addr = s.rs; rt_addr = s.rt;
    @(negedge clk);
    obs.ready = aux_ready; obs.brs = busy_rs; obs.brt = busy_rt; obs.stall = stall_req;
    obs.we = grf_we; obs.a3 = grf_a3; obs.wd = grf_wd; obs.wpc = grf_wpc;
    e = model_eval(s);
    cmp_outs({tag, ".model"}, obs, e);
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  vec_t  tbl [9];
  stim_t s;

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
    aux_valid = 1'b0; aux_addr = '0; aux_data = '0; aux_pc = '0;
    rs_addr = '0; rt_addr = '0;
    @(posedge clk);
    #1;

    // ---------------- directed vector table ----------------
    //                 rst wbv wba  wbd           wbp         auxv auxa  auxd          auxp         rs  rt
    tbl[0].s = mk_s(1, 1, 5'd4, 32'h1111_1111, 32'h10,     1, 5'd3, 32'h2222_2222, 32'h20,     5'd3, 5'd4);
    tbl[0].e = mk_e(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tbl[1].s = mk_s(0, 0, 5'd0, 32'h0,         32'h0,      1, 5'd8, 32'h1234_5678, 32'h100,    5'd8, 5'd0);
    tbl[1].e = mk_e(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tbl[2].s = mk_s(0, 0, 5'd0, 32'h0,         32'h0,      0, 5'd0, 32'h0,         32'h0,      5'd8, 5'd0);
    tbl[2].e = mk_e(1, 1, 0, 0, 1, 5'd8, 32'h1234_5678, 32'h100);
    tbl[3].s = mk_s(0, 0, 5'd0, 32'h0,         32'h0,      0, 5'd0, 32'h0,         32'h0,      5'd8, 5'd0);
    tbl[3].e = mk_e(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tbl[4].s = mk_s(0, 0, 5'd0, 32'h0,         32'h0,      1, 5'd9, 32'hAAAA_5555, 32'h200,    5'd0, 5'd9);
    tbl[4].e = mk_e(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tbl[5].s = mk_s(0, 1, 5'd0, 32'hFFFF_FFFF, 32'h300,    0, 5'd0, 32'h0,         32'h0,      5'd0, 5'd9);
    tbl[5].e = mk_e(1, 0, 1, 0, 1, 5'd9, 32'hAAAA_5555, 32'h200);
    tbl[6].s = mk_s(0, 0, 5'd0, 32'h0,         32'h0,      1, 5'd0, 32'h0000_0055, 32'h400,    5'd0, 5'd0);
    tbl[6].e = mk_e(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tbl[7].s = mk_s(0, 0, 5'd0, 32'h0,         32'h0,      0, 5'd0, 32'h0,         32'h0,      5'd0, 5'd0);
    tbl[7].e = mk_e(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    tbl[8].s = mk_s(0, 1, 5'd5, 32'hDEAD_BEEF, 32'h3000,   0, 5'd0, 32'h0,         32'h0,      5'd5, 5'd0);
    tbl[8].e = mk_e(1, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 32'h3000);

    for (int i = 0; i < 9; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].s);
      cmp_outs($sformatf("vec%0d", i), obs, tbl[i].e);
    end

    // ---------------- fill + starvation sequence ----------------
    for (int k = 0; k < 11; k++) begin
      s = mk_s(0, (k < 9), 5'd1, 32'h5000 + 32'(k), 32'h6000 + 32'(k),
               (k < 5), (k < 4) ? 5'(10 + k) : 5'd20, 32'hA000 + 32'(k), 32'hB000 + 32'(k),
               5'd10, 5'd13);
      cycle($sformatf("fill%0d", k), s);
      if (k < 4)              chk($sformatf("fill%0d.ready", k), 32'(obs.ready), 32'd1);
      if (k >= 4 && k <= 9)   chk($sformatf("fill%0d.ready", k), 32'(obs.ready), 32'd0);
      if (k >= 1 && k <= 8) begin
        chk($sformatf("fill%0d.a3", k),    32'(obs.a3),    32'd1);
        chk($sformatf("fill%0d.stall", k), 32'(obs.stall), (k == 8) ? 32'd1 : 32'd0);
      end
      if (k == 9) begin
        chk("fill9.we",    32'(obs.we),    32'd1);
        chk("fill9.a3",    32'(obs.a3),    32'd10);
        chk("fill9.wd",    obs.wd,         32'hA000);
        chk("fill9.stall", 32'(obs.stall), 32'd0);
      end
      if (k == 10) chk("fill10.ready", 32'(obs.ready), 32'd1);
    end

    // ---------------- reset with buffered entries ----------------
    cycle("rst0", mk_s(1, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0));
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("rfill%0d", k),
            mk_s(0, 1, 5'd2, 32'h7000, 32'h7100, 1, 5'(11 + k), 32'hC000 + 32'(k), 32'hD000, 5'd11, 5'd13));
    end
    cycle("rpulse", mk_s(1, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 5'd11, 5'd13));
    chk("rpulse.we",    32'(obs.we),    32'd0);
    chk("rpulse.ready", 32'(obs.ready), 32'd1);
    chk("rpulse.busy",  32'(obs.brs),   32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("rpost%0d", k), mk_s(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 5'd11, 5'd13));
      chk($sformatf("rpost%0d.we", k),      32'(obs.we),  32'd0);
      chk($sformatf("rpost%0d.busy_rs", k), 32'(obs.brs), 32'd0);
      chk($sformatf("rpost%0d.busy_rt", k), 32'(obs.brt), 32'd0);
      chk($sformatf("rpost%0d.ready", k),   32'(obs.ready), 32'd1);
    end

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < 600; k++) begin
      s.rst  = ($urandom_range(0, 59) == 0);
      s.wbv  = obs.stall ? 1'b0 : ($urandom_range(0, 9) < 6);
      s.wba  = 5'($urandom_range(0, 7));
      s.wbd  = $urandom;
      s.wbp  = $urandom;
      s.auxv = ($urandom_range(0, 1) == 1);
      s.auxa = 5'($urandom_range(0, 7));
      s.auxd = $urandom;
      s.auxp = $urandom;
      s.rs   = 5'($urandom_range(0, 7));
      s.rt   = 5'($urandom_range(0, 7));
      cycle($sformatf("rnd%0d", k), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
